hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_W, default 5, register-address width.
REQ-002 SHALL have parameter T_W, default 2, width of every Tnew/Tuse value.
REQ-003 SHALL have parameter MULT_LAT, default 5, multiply busy cycles (1..2^CNT_MD-1).
REQ-004 SHALL have parameter DIV_LAT, default 10, divide busy cycles (1..2^CNT_MD-1).
REQ-005 SHALL have parameter CNT_MD, default 4, width of the mult/div countdown.
REQ-006 SHALL have parameter STAT_W, default 16, width of the stall statistics counter.
REQ-007 SHALL have ports (name dir width meaning):
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- D_rs, D_rt  in  REG_W  D-stage source registers.
- D_tuse_rs, D_tuse_rt  in  T_W  D-stage Tuse per source.
- D_is_md  in  1  D instruction reads/writes HI/LO (mult/div/mfhi/mflo/mthi/mtlo).
- E_rs, E_rt, E_wra  in  REG_W  E-stage sources and destination (0 = none).
- E_tnew  in  T_W  E-stage Tnew.
- M_rt, M_wra  in  REG_W  M-stage store source and destination.
- W_wra  in  REG_W  W-stage destination.
- md_start  in  1  one-cycle pulse: mult/div issued in E.
- md_is_div  in  1  qualifies md_start: 1 = divide, 0 = multiply.
- stat_clr  in  1  synchronous clear of stall_count.
- stall  out  1  freeze F/D, insert bubble into E.
- fwd_rs_D, fwd_rt_D  out  2  D operand source: 00 RF, 01 E, 10 M.
- fwd_a_E, fwd_b_E  out  2  E operand source: 00 pipe reg, 01 M, 10 W.
- fwd_M  out  1  M store data from W.
- md_busy  out  1  mult/div unit occupied.
- stall_count  out  STAT_W  cumulative stall cycles.

Function
REQ-008 SHALL hold an internal M_tnew register, updated every clock to E_tnew-1, saturating at 0.
REQ-009 SHALL assert stall when, for src in {rs,rt}: D_src!=0 and ((D_src==E_wra and E_tnew>D_tuse_src) or (D_src==M_wra and M_tnew>D_tuse_src)).
REQ-010 SHALL also assert stall when D_is_md=1 and (md_busy=1 or md_start=1).
REQ-011 SHALL drive stall combinationally, in the same cycle as its causing inputs.
REQ-012 SHALL set fwd_src_D=01 when D_src!=0, D_src==E_wra and E_tnew==0; otherwise 10 when D_src!=0 and D_src==M_wra; otherwise 00 (E priority over M).
REQ-013 SHALL set fwd_a_E/fwd_b_E=01 when source!=0 and ==M_wra; otherwise 10 when source!=0 and ==W_wra; otherwise 00 (M priority over W).
REQ-014 SHALL set fwd_M=1 iff M_rt!=0 and M_rt==W_wra.
REQ-015 SHALL load the md countdown on md_start with MULT_LAT (md_is_div=0) or DIV_LAT (md_is_div=1), and decrement by 1 per clock while nonzero.
REQ-016 SHALL drive md_busy = (countdown!=0), registered; md_busy falls exactly LAT cycles after the md_start edge.
REQ-017 SHALL reload the countdown when md_start occurs while busy (latest issue wins, no accumulation).
REQ-018 SHALL increment stall_count on each clock where stall=1, saturating at all-ones.
REQ-019 SHALL give stat_clr priority over increment: count becomes 0 even when stall=1.
REQ-020 SHALL treat register 0 as never hazarding and never forwarded, regardless of Tnew.

Reset
REQ-021 SHALL, on reset_n low, immediately clear M_tnew, the md countdown, md_busy and stall_count to 0, independent of clk.
REQ-022 SHALL, during reset, drive combinational outputs from inputs only, with M_tnew=0 and md_busy=0 in effect.
REQ-023 SHALL discard an in-flight mult/div countdown when reset asserts mid-operation; after release md_busy=0 until the next md_start.

Verification
REQ-024 Load-use: E_wra=8, E_tnew=2, D_rs=8, D_tuse_rs=1 -> stall=1, stall_count 0->1; next cycle M_wra=8 with M_tnew=1 -> stall=0, fwd_rs_D=10.
REQ-025 Branch on ALU result: D_rt=5, D_tuse_rt=0, E_wra=5, E_tnew=1 -> stall=1; with E_tnew=0 -> stall=0, fwd_rt_D=01.
REQ-026 Divide then mflo: md_start=1, md_is_div=1, D_is_md=1 -> stall=1 for exactly 11 cycles (start cycle plus 10 busy), md_busy deasserts on cycle 10.
REQ-027 E forwarding priority: E_rs=3, M_wra=3, W_wra=3 -> fwd_a_E=01; same with E_rs=0 -> 00; M_rt=W_wra=7 -> fwd_M=1.
REQ-028 Reset mid-multiply: reset_n low 2 cycles after md_start -> md_busy=0 asynchronously, stall_count=0, no stall for D_is_md after release.
REQ-029 Saturation/clear: STAT_W=4, stall held 20 cycles -> stall_count=15; stat_clr=1 with stall=1 -> 0.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - pipeline hazard bundle between datapath (master) and scoreboard (slave)
interface hazard_scoreboard_if #(
  parameter int REG_W  = 5,
  parameter int T_W    = 2,
  parameter int STAT_W = 16
);
  logic [REG_W-1:0]  D_rs, D_rt;
  logic [T_W-1:0]    D_tuse_rs, D_tuse_rt;
  logic              D_is_md;
  logic [REG_W-1:0]  E_rs, E_rt, E_wra;
  logic [T_W-1:0]    E_tnew;
  logic [REG_W-1:0]  M_rt, M_wra;
  logic [REG_W-1:0]  W_wra;
  logic              md_start, md_is_div;
  logic              stat_clr;
  logic              stall;
  logic [1:0]        fwd_rs_D, fwd_rt_D;
  logic [1:0]        fwd_a_E, fwd_b_E;
  logic              fwd_M;
  logic              md_busy;
  logic [STAT_W-1:0] stall_count;

  modport master (
    output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
    output E_rs, E_rt, E_wra, E_tnew, M_rt, M_wra, W_wra,
    output md_start, md_is_div, stat_clr,
    input  stall, fwd_rs_D, fwd_rt_D, fwd_a_E, fwd_b_E, fwd_M, md_busy, stall_count
  );

  modport slave (
    input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
    input  E_rs, E_rt, E_wra, E_tnew, M_rt, M_wra, W_wra,
    input  md_start, md_is_div, stat_clr,
    output stall, fwd_rs_D, fwd_rt_D, fwd_a_E, fwd_b_E, fwd_M, md_busy, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - Tnew/Tuse stall, forwarding select and mult/div busy tracking
module hazard_scoreboard #(
  parameter int REG_W    = 5,
  parameter int T_W      = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_MD   = 4,
  parameter int STAT_W   = 16
) (
  input logic               clk,
  input logic               reset_n,
  hazard_scoreboard_if.slave hz
);

  localparam logic [REG_W-1:0] R0 = '0;

  logic [T_W-1:0]    m_tnew;
  logic [CNT_MD-1:0] md_cnt;
  logic [STAT_W-1:0] stall_cnt;

  logic rs_hit_e, rs_hit_m, rt_hit_e, rt_hit_m;
  logic stall_haz, stall_md, stall_w;

  // Register 0 is hardwired to zero, so it never matches a producer.
  assign rs_hit_e = (hz.D_rs != R0) && (hz.D_rs == hz.E_wra);
  assign rs_hit_m = (hz.D_rs != R0) && (hz.D_rs == hz.M_wra);
  assign rt_hit_e = (hz.D_rt != R0) && (hz.D_rt == hz.E_wra);
  assign rt_hit_m = (hz.D_rt != R0) && (hz.D_rt == hz.M_wra);

  assign stall_haz = (rs_hit_e && (hz.E_tnew > hz.D_tuse_rs)) ||
                     (rs_hit_m && (m_tnew   > hz.D_tuse_rs)) ||
                     (rt_hit_e && (hz.E_tnew > hz.D_tuse_rt)) ||
                     (rt_hit_m && (m_tnew   > hz.D_tuse_rt));

  assign stall_md = hz.D_is_md && (hz.md_busy || hz.md_start);
  assign stall_w  = stall_haz || stall_md;

  assign hz.stall       = stall_w;
  assign hz.md_busy     = (md_cnt != '0);
  assign hz.stall_count = stall_cnt;
  assign hz.fwd_M       = (hz.M_rt != R0) && (hz.M_rt == hz.W_wra);

  always_comb begin
    hz.fwd_rs_D = 2'b00;
    hz.fwd_rt_D = 2'b00;
    hz.fwd_a_E  = 2'b00;
    hz.fwd_b_E  = 2'b00;
    // E result is only forwardable once it is ready (Tnew 0); otherwise fall back to M.
    if (rs_hit_e && (hz.E_tnew == '0)) hz.fwd_rs_D = 2'b01;
    else if (rs_hit_m)                 hz.fwd_rs_D = 2'b10;
    if (rt_hit_e && (hz.E_tnew == '0)) hz.fwd_rt_D = 2'b01;
    else if (rt_hit_m)                 hz.fwd_rt_D = 2'b10;
    if ((hz.E_rs != R0) && (hz.E_rs == hz.M_wra))      hz.fwd_a_E = 2'b01;
    else if ((hz.E_rs != R0) && (hz.E_rs == hz.W_wra)) hz.fwd_a_E = 2'b10;
    if ((hz.E_rt != R0) && (hz.E_rt == hz.M_wra))      hz.fwd_b_E = 2'b01;
    else if ((hz.E_rt != R0) && (hz.E_rt == hz.W_wra)) hz.fwd_b_E = 2'b10;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_tnew <= '0;
    end else begin
      m_tnew <= (hz.E_tnew == '0) ? '0 : hz.E_tnew - T_W'(1);
    end
  end

  // A new issue always reloads, so back-to-back ops track only the latest.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_cnt <= '0;
    end else if (hz.md_start) begin
      md_cnt <= hz.md_is_div ? CNT_MD'(DIV_LAT) : CNT_MD'(MULT_LAT);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CNT_MD'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (hz.stat_clr) begin
      stall_cnt <= '0;
    end else if (stall_w && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed vector bench for hazard_scoreboard
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.STAT_W(4)) hz ();
  hazard_scoreboard #(.STAT_W(4)) dut (.clk(clk), .reset_n(reset_n), .hz(hz));

  typedef struct {
    int d_rs, d_rt, tu_rs, tu_rt;
    int e_rs, e_rt, e_wra, e_tnew;
    int m_tnew, m_rt, m_wra, w_wra;
    int st, frs, frt, fa, fb, fm;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic zero_inputs();
    hz.D_rs = '0; hz.D_rt = '0; hz.D_tuse_rs = '0; hz.D_tuse_rt = '0; hz.D_is_md = 1'b0;
    hz.E_rs = '0; hz.E_rt = '0; hz.E_wra = '0; hz.E_tnew = '0;
    hz.M_rt = '0; hz.M_wra = '0; hz.W_wra = '0;
    hz.md_start = 1'b0; hz.md_is_div = 1'b0; hz.stat_clr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Precondition M_tnew with one clock of E_tnew, then present the vector.
  task automatic apply_vec(input int idx, input vec_t v);
    zero_inputs();
    hz.E_tnew = (v.m_tnew == 0) ? 2'd0 : 2'(v.m_tnew + 1);
    tick();
    hz.D_rs = 5'(v.d_rs); hz.D_rt = 5'(v.d_rt);
    hz.D_tuse_rs = 2'(v.tu_rs); hz.D_tuse_rt = 2'(v.tu_rt);
    hz.E_rs = 5'(v.e_rs); hz.E_rt = 5'(v.e_rt); hz.E_wra = 5'(v.e_wra);
    hz.E_tnew = 2'(v.e_tnew);
    hz.M_rt = 5'(v.m_rt); hz.M_wra = 5'(v.m_wra); hz.W_wra = 5'(v.w_wra);
    #1;
    chk($sformatf("v%0d_stall", idx), 32'(hz.stall), 32'(v.st));
    chk($sformatf("v%0d_fwd_rs_D", idx), 32'(hz.fwd_rs_D), 32'(v.frs));
    chk($sformatf("v%0d_fwd_rt_D", idx), 32'(hz.fwd_rt_D), 32'(v.frt));
    chk($sformatf("v%0d_fwd_a_E", idx), 32'(hz.fwd_a_E), 32'(v.fa));
    chk($sformatf("v%0d_fwd_b_E", idx), 32'(hz.fwd_b_E), 32'(v.fb));
    chk($sformatf("v%0d_fwd_M", idx), 32'(hz.fwd_M), 32'(v.fm));
  endtask

  initial begin
    int stall_n;
    int busy_n;
    int seen;

    //         d_rs d_rt tur tut e_rs e_rt e_wra e_tn m_tn m_rt m_wra w_wra  st frs frt fa fb fm
    vecs[0]  = '{ 0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,   0, 0, 0, 0, 0, 0};
    vecs[1]  = '{ 0,  5,  0,  0,  0,  0,  5,  1,  0,  0,  0,  0,   1, 0, 0, 0, 0, 0};
    vecs[2]  = '{ 0,  5,  0,  0,  0,  0,  5,  0,  0,  0,  0,  0,   0, 0, 1, 0, 0, 0};
    vecs[3]  = '{ 9,  0,  0,  0,  0,  0,  0,  0,  1,  0,  9,  0,   1, 2, 0, 0, 0, 0};
    vecs[4]  = '{ 9,  0,  1,  0,  0,  0,  0,  0,  1,  0,  9,  0,   0, 2, 0, 0, 0, 0};
    vecs[5]  = '{ 4,  0,  0,  0,  0,  0,  4,  0,  0,  0,  4,  0,   0, 1, 0, 0, 0, 0};
    vecs[6]  = '{ 0,  0,  0,  0,  0,  0,  0,  3,  2,  0,  0,  0,   0, 0, 0, 0, 0, 0};
    vecs[7]  = '{ 0,  0,  0,  0,  3,  3,  0,  0,  0,  0,  3,  3,   0, 0, 0, 1, 1, 0};
    vecs[8]  = '{ 0,  0,  0,  0,  0,  3,  0,  0,  0,  0,  3,  3,   0, 0, 0, 0, 1, 0};
    vecs[9]  = '{ 0,  0,  0,  0,  6,  2,  0,  0,  0,  0,  2,  6,   0, 0, 0, 2, 1, 0};
    vecs[10] = '{ 0,  0,  0,  0,  7,  0,  0,  0,  0,  7,  0,  7,   0, 0, 0, 2, 0, 1};
    vecs[11] = '{12,  0,  2,  0,  0,  0, 12,  2,  0,  0,  0,  0,   0, 0, 0, 0, 0, 0};
    vecs[12] = '{ 1,  2,  0,  2,  0,  0,  2,  3,  0,  0,  0,  0,   1, 0, 0, 0, 0, 0};
    vecs[13] = '{10,  0,  1,  0,  0,  0,  0,  0,  2,  0, 10,  0,   1, 2, 0, 0, 0, 0};
    vecs[14] = '{10,  0,  0,  0,  0,  0,  0,  0,  0,  0, 10,  0,   0, 2, 0, 0, 0, 0};
    vecs[15] = '{ 0, 11,  0,  0,  0,  0,  0,  0,  0, 11, 11, 11,   0, 0, 2, 0, 0, 1};

    // Reset: M_tnew held at 0 even though E_tnew is clocked at 3.
    zero_inputs();
    hz.E_tnew = 2'd3;
    tick();
    tick();
    hz.D_rs = 5'd9; hz.M_wra = 5'd9; hz.D_tuse_rs = 2'd0; hz.E_tnew = 2'd0;
    #1;
    chk("rst_md_busy", 32'(hz.md_busy), 32'd0);
    chk("rst_stall_count", 32'(hz.stall_count), 32'd0);
    chk("rst_m_tnew_no_stall", 32'(hz.stall), 32'd0);
    chk("rst_fwd_rs_D", 32'(hz.fwd_rs_D), 32'd2);
    reset_n = 1'b1;
    zero_inputs();
    tick();

    // Load-use: E hazard, then the same producer in M with Tnew 1.
    hz.E_wra = 5'd8; hz.E_tnew = 2'd2; hz.D_rs = 5'd8; hz.D_tuse_rs = 2'd1;
    #1;
    chk("lu_stall", 32'(hz.stall), 32'd1);
    chk("lu_count0", 32'(hz.stall_count), 32'd0);
    tick();
    chk("lu_count1", 32'(hz.stall_count), 32'd1);
    hz.E_wra = 5'd0; hz.E_tnew = 2'd0; hz.M_wra = 5'd8;
    #1;
    chk("lu_m_stall", 32'(hz.stall), 32'd0);
    chk("lu_m_fwd_rs_D", 32'(hz.fwd_rs_D), 32'd2);

    for (int i = 0; i < 16; i++) apply_vec(i, vecs[i]);

    // Divide followed by a HI/LO reader.
    zero_inputs();
    tick();
    hz.D_is_md = 1'b1; hz.md_start = 1'b1; hz.md_is_div = 1'b1;
    #1;
    chk("div_start_stall", 32'(hz.stall), 32'd1);
    chk("div_start_busy", 32'(hz.md_busy), 32'd0);
    stall_n = 1;
    busy_n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      hz.md_start = 1'b0;
      #1;
      if (hz.stall) stall_n++;
      if (hz.md_busy) busy_n++;
    end
    chk("div_stall_cycles", 32'(stall_n), 32'd11);
    chk("div_busy_cycles", 32'(busy_n), 32'd10);

    // Reissue while busy: divide issued 2 cycles into a multiply reloads.
    zero_inputs();
    tick();
    hz.md_start = 1'b1; hz.md_is_div = 1'b0;
    tick();
    hz.md_start = 1'b0;
    tick();
    hz.md_start = 1'b1; hz.md_is_div = 1'b1;
    tick();
    hz.md_start = 1'b0;
    busy_n = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (hz.md_busy) busy_n++;
      tick();
    end
    chk("reload_busy_cycles", 32'(busy_n), 32'd10);

    // Saturation and clear priority.
    zero_inputs();
    hz.stat_clr = 1'b1;
    tick();
    chk("clr_count", 32'(hz.stall_count), 32'd0);
    hz.stat_clr = 1'b0;
    hz.E_wra = 5'd8; hz.E_tnew = 2'd2; hz.D_rs = 5'd8; hz.D_tuse_rs = 2'd1;
    for (int i = 0; i < 14; i++) tick();
    chk("sat_count14", 32'(hz.stall_count), 32'd14);
    for (int i = 0; i < 6; i++) tick();
    chk("sat_count20", 32'(hz.stall_count), 32'd15);
    hz.stat_clr = 1'b1;
    #1;
    chk("clr_with_stall", 32'(hz.stall), 32'd1);
    tick();
    chk("clr_over_inc", 32'(hz.stall_count), 32'd0);
    hz.stat_clr = 1'b0;
    tick();
    chk("inc_after_clr", 32'(hz.stall_count), 32'd1);

    // Reset in the middle of a multiply.
    zero_inputs();
    hz.md_start = 1'b1; hz.md_is_div = 1'b0;
    tick();
    hz.md_start = 1'b0;
    hz.E_wra = 5'd8; hz.E_tnew = 2'd2; hz.D_rs = 5'd8; hz.D_tuse_rs = 2'd1;
    tick();
    tick();
    chk("mul_busy_pre_rst", 32'(hz.md_busy), 32'd1);
    chk("count_pre_rst", 32'(hz.stall_count), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mul_busy_async_rst", 32'(hz.md_busy), 32'd0);
    chk("count_async_rst", 32'(hz.stall_count), 32'd0);
    tick();
    reset_n = 1'b1;
    zero_inputs();
    hz.D_is_md = 1'b1;
    #1;
    chk("post_rst_md_stall", 32'(hz.stall), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (hz.md_busy || hz.stall) seen++;
    end
    chk("post_rst_idle", 32'(seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
